line_mem_responder: RTL and testbench

- Slow line-granular main-memory model; the responder end of the cache-to-memory line protocol (addr, rd_req/wr_req, rd_line/wr_line, gnt).
- Sits below the cache. It services one whole-line read or write per request with a fixed, configurable latency.
- It signals completion with a one-cycle gnt pulse.
- It replaces the behavioural memory used in cache benches with a synthesizable, cycle-exact responder.

---
 rtl/line_mem_responder_pkg.sv | 19 +
 rtl/line_mem_responder_if.sv | 23 ++
 rtl/line_mem_responder_storage.sv | 44 ++++
 rtl/line_mem_responder.sv | 96 +++++++++
 tb/tb_line_mem_responder.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/line_mem_responder_pkg.sv
// Shared types and helpers for the line-granular memory responder.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } mem_op_t;

    function automatic int line_size(input int line_addr_len);
        return 1 << line_addr_len;
    endfunction

endpackage

// File: rtl/line_mem_responder_if.sv
// Cache-to-memory line bus: the cache is the master, the memory responder the slave.
interface line_mem_if #(
    parameter int ADDR_LEN  = 10,
    parameter int LINE_SIZE = 8
);
    logic [ADDR_LEN-1:0] addr;
    logic                rd_req;
    logic                wr_req;
    logic [31:0]         wr_line [LINE_SIZE];
    logic [31:0]         rd_line [LINE_SIZE];
    logic                gnt;

    modport master (
        output addr, rd_req, wr_req, wr_line,
        input  rd_line, gnt
    );

    modport slave (
        input  addr, rd_req, wr_req, wr_line,
        output rd_line, gnt
    );

endinterface

// File: rtl/line_mem_responder_storage.sv
// Line-wide storage array: one synchronous line write port, one combinational line read port.
module line_storage
    import mem_resp_pkg::*;
#(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 10,
    parameter int LINE_SIZE     = 8
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_LEN-1:0] waddr,
    input  logic [31:0]         wdata [LINE_SIZE],
    input  logic [ADDR_LEN-1:0] raddr,
    output logic [31:0]         rdata [LINE_SIZE]
);

    localparam int IDX_W     = ADDR_LEN + LINE_ADDR_LEN;
    localparam int NUM_WORDS = 1 << IDX_W;

    // Each word is stored XORed with its own flat index, so the all-zero
    // power-up image reads back as the index pattern L*LINE_SIZE + w.
    logic [31:0] mem [NUM_WORDS] = '{default: '0};

    function automatic logic [31:0] word_key(input logic [ADDR_LEN-1:0] line, input int w);
        logic [LINE_ADDR_LEN-1:0] off;
        off = LINE_ADDR_LEN'(w);
        return 32'({line, off});
    endfunction

    always_ff @(posedge clk) begin
        if (we) begin
            for (int w = 0; w < LINE_SIZE; w++) begin
                mem[{waddr, LINE_ADDR_LEN'(w)}] <= wdata[w] ^ word_key(waddr, w);
            end
        end
    end

    always_comb begin
        for (int w = 0; w < LINE_SIZE; w++) begin
            rdata[w] = mem[{raddr, LINE_ADDR_LEN'(w)}] ^ word_key(raddr, w);
        end
    end

endmodule

// File: rtl/line_mem_responder.sv
// Fixed-latency line memory responder: accepts one whole-line read or write, answers with a one-cycle gnt.
module line_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 10,
    parameter int LATENCY       = 50
) (
    input  logic     clk,
    input  logic     rst_n,
    line_mem_if.slave bus
);

    localparam int LINE_SIZE = line_size(LINE_ADDR_LEN);
    localparam int CNT_W     = $clog2(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

    resp_state_t         state;
    logic [CNT_W-1:0]    count;
    logic [ADDR_LEN-1:0] lat_addr;
    mem_op_t             lat_op;
    logic [31:0]         lat_data  [LINE_SIZE];
    logic [31:0]         rd_line_q [LINE_SIZE];
    logic [31:0]         store_rd  [LINE_SIZE];
    logic                gnt_q;
    logic                req_held;
    logic                store_we;

    assign req_held = (lat_op == OP_WR) ? bus.wr_req : bus.rd_req;
    assign store_we = (state == RESP) && (lat_op == OP_WR);

    assign bus.gnt     = gnt_q;
    assign bus.rd_line = rd_line_q;

    line_storage #(
        .LINE_ADDR_LEN(LINE_ADDR_LEN),
        .ADDR_LEN     (ADDR_LEN),
        .LINE_SIZE    (LINE_SIZE)
    ) u_storage (
        .clk  (clk),
        .we   (store_we),
        .waddr(lat_addr),
        .wdata(lat_data),
        .raddr(lat_addr),
        .rdata(store_rd)
    );

    // Counter is loaded with LATENCY-2 so that the RESP cycle lands exactly
    // LATENCY cycles after the request was first seen in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            gnt_q     <= 1'b0;
            lat_addr  <= '0;
            lat_op    <= OP_RD;
            lat_data  <= '{default: '0};
            rd_line_q <= '{default: '0};
        end else begin
            gnt_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wr_req || bus.rd_req) begin
                        lat_addr <= bus.addr;
                        lat_op   <= bus.wr_req ? OP_WR : OP_RD;
                        if (bus.wr_req) begin
                            lat_data <= bus.wr_line;
                        end
                        count <= CNT_LOAD;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!req_held) begin
                        state <= IDLE;
                    end else if (count == '0) begin
                        state <= RESP;
                        gnt_q <= 1'b1;
                        if (lat_op == OP_RD) begin
                            rd_line_q <= store_rd;
                        end
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed self-checking bench for line_mem_responder with LATENCY=4.
module tb_line_mem_responder;
    import mem_resp_pkg::*;

    localparam int LINE_ADDR_LEN = 3;
    localparam int ADDR_LEN      = 10;
    localparam int LATENCY       = 4;
    localparam int LINE_SIZE     = line_size(LINE_ADDR_LEN);

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   g;

    line_mem_if #(.ADDR_LEN(ADDR_LEN), .LINE_SIZE(LINE_SIZE)) bus ();

    line_mem_responder #(
        .LINE_ADDR_LEN(LINE_ADDR_LEN),
        .ADDR_LEN     (ADDR_LEN),
        .LATENCY      (LATENCY)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkLine(input string tag, input logic [31:0] base, input logic [31:0] step);
        for (int w = 0; w < LINE_SIZE; w++) begin
            checkOutput($sformatf("%s[%0d]", tag, w), bus.rd_line[w], base + step * 32'(w));
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Issues a request in the current cycle (cycle 0), scrambles addr/data after
    // acceptance, holds the request until gnt and returns in the cycle after gnt.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [ADDR_LEN-1:0] a,
                                 input logic [31:0] base, output int gnt_cyc);
        gnt_cyc     = -1;
        bus.addr    = a;
        bus.wr_req  = wr;
        bus.rd_req  = rd;
        for (int w = 0; w < LINE_SIZE; w++) bus.wr_line[w] = base + 32'(w);
        for (int k = 0; k <= 20 && gnt_cyc < 0; k++) begin
            @(negedge clk);
            if (bus.gnt) gnt_cyc = k;
            nextCycle();
            if (k == 0) begin
                bus.addr = ~a;
                for (int w = 0; w < LINE_SIZE; w++) bus.wr_line[w] = 32'hDEAD_0000 + 32'(w);
            end
        end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        bus.addr   = '0;
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        for (int w = 0; w < LINE_SIZE; w++) bus.wr_line[w] = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_gnt", 32'(bus.gnt), 32'd0);
        checkLine("reset_rd_line", 32'd0, 32'd0);
        rst_n = 1'b1;
        nextCycle();

        applyStimulus(1'b0, 1'b1, 10'd5, 32'd0, g);
        checkOutput("rd5_gnt_cycle", 32'(g), 32'd4);
        checkOutput("rd5_gnt_low_after", 32'(bus.gnt), 32'd0);
        checkLine("rd5_data", 32'd40, 32'd1);
        repeat (2) nextCycle();
        checkLine("rd5_data_held", 32'd40, 32'd1);

        applyStimulus(1'b1, 1'b0, 10'd3, 32'hA5A5_0000, g);
        checkOutput("wr3_gnt_cycle", 32'(g), 32'd4);
        checkLine("wr3_rd_line_kept", 32'd40, 32'd1);
        applyStimulus(1'b0, 1'b1, 10'd3, 32'd0, g);
        checkOutput("rd3_gnt_cycle", 32'(g), 32'd4);
        checkLine("rd3_after_wr", 32'hA5A5_0000, 32'd1);
        applyStimulus(1'b0, 1'b1, 10'd4, 32'd0, g);
        checkOutput("rd4_gnt_cycle", 32'(g), 32'd4);
        checkLine("rd4_untouched", 32'd32, 32'd1);

        applyStimulus(1'b1, 1'b1, 10'd7, 32'h7700_0000, g);
        checkOutput("both7_gnt_cycle", 32'(g), 32'd4);
        checkLine("both7_rd_line_kept", 32'd32, 32'd1);
        applyStimulus(1'b0, 1'b1, 10'd7, 32'd0, g);
        checkOutput("rd7_gnt_cycle", 32'(g), 32'd4);
        checkLine("rd7_written", 32'h7700_0000, 32'd1);

        bus.addr   = 10'd2;
        bus.wr_req = 1'b1;
        for (int w = 0; w < LINE_SIZE; w++) bus.wr_line[w] = 32'hBEEF_0000 + 32'(w);
        @(negedge clk);
        checkOutput("abort_gnt_c0", 32'(bus.gnt), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("abort_gnt_c1", 32'(bus.gnt), 32'd0);
        nextCycle();
        bus.wr_req = 1'b0;
        @(negedge clk);
        checkOutput("abort_gnt_c2", 32'(bus.gnt), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 10'd2, 32'd0, g);
        checkOutput("after_abort_gnt_cycle", 32'(g), 32'd4);
        checkLine("rd2_not_written", 32'd16, 32'd1);

        applyStimulus(1'b1, 1'b0, 10'd1, 32'h1111_0000, g);
        checkOutput("b2b_wr1_gnt_cycle", 32'(g), 32'd4);
        checkLine("b2b_rd_line_kept", 32'd16, 32'd1);
        applyStimulus(1'b0, 1'b1, 10'd9, 32'd0, g);
        checkOutput("b2b_rd9_gnt_cycle", 32'(g), 32'd4);
        checkLine("b2b_rd9_data", 32'd72, 32'd1);
        applyStimulus(1'b0, 1'b1, 10'd1, 32'd0, g);
        checkOutput("rd1_gnt_cycle", 32'(g), 32'd4);
        checkLine("rd1_written", 32'h1111_0000, 32'd1);
        applyStimulus(1'b0, 1'b1, 10'h3FF, 32'd0, g);
        checkOutput("rd_top_gnt_cycle", 32'(g), 32'd4);
        checkLine("rd_top_line", 32'd8184, 32'd1);

        bus.addr   = 10'd6;
        bus.wr_req = 1'b1;
        for (int w = 0; w < LINE_SIZE; w++) bus.wr_line[w] = 32'hCAFE_0000 + 32'(w);
        nextCycle();
        nextCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_gnt", 32'(bus.gnt), 32'd0);
        checkLine("midreset_rd_line", 32'd0, 32'd0);
        bus.wr_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
        applyStimulus(1'b0, 1'b1, 10'd6, 32'd0, g);
        checkOutput("rd6_gnt_cycle", 32'(g), 32'd4);
        checkLine("rd6_not_committed", 32'd48, 32'd1);
        @(negedge clk);
        checkOutput("final_gnt_low", 32'(bus.gnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
